// File: rtl/icache_ro_pkg.sv
// Shared configuration, derived address-split widths and FSM encoding for the
// read-only direct-mapped instruction cache.
package icache_ro_pkg;

    localparam int unsigned LINES          = 16;
    localparam int unsigned LINE_BEATS     = 4;
    localparam int unsigned MEM_DATA_BITS  = 128;
    localparam int unsigned WORD_BITS      = 32;

    localparam int unsigned WORDS_PER_BEAT = MEM_DATA_BITS / WORD_BITS;
    localparam int unsigned WPB_W          = $clog2(WORDS_PER_BEAT);
    localparam int unsigned BEAT_W         = $clog2(LINE_BEATS);
    localparam int unsigned WSEL_W         = BEAT_W + WPB_W;
    localparam int unsigned OFF_W          = WSEL_W + 2;
    localparam int unsigned IDX_W          = $clog2(LINES);
    localparam int unsigned TAG_W          = 32 - OFF_W - IDX_W;
    localparam int unsigned WADDR_W        = 30;
    localparam int unsigned MEM_ADDR_W     = 32 - $clog2(MEM_DATA_BITS / 8);

    typedef enum logic [1:0] {
        ICACHE_READY     = 2'd0,
        ICACHE_MISS_REQ  = 2'd1,
        ICACHE_MISS_RESP = 2'd2,
        ICACHE_FILL_DONE = 2'd3
    } icache_state_e;

endpackage

// File: rtl/icache_ro_array.sv
// Valid/tag/data storage: beat-granular fill write port, tag commit port and a
// combinational word-granular lookup port.
module icache_array
    import icache_ro_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     beat_we_i,
    input  logic [IDX_W-1:0]         beat_idx_i,
    input  logic [BEAT_W-1:0]        beat_sel_i,
    input  logic [MEM_DATA_BITS-1:0] beat_data_i,
    input  logic                     tag_we_i,
    input  logic [IDX_W-1:0]         tag_idx_i,
    input  logic [TAG_W-1:0]         tag_i,
    input  logic [IDX_W-1:0]         rd_idx_i,
    input  logic [WSEL_W-1:0]        rd_wsel_i,
    output logic                     rd_valid_o,
    output logic [TAG_W-1:0]         rd_tag_o,
    output logic [WORD_BITS-1:0]     rd_word_o
);

    logic [LINES-1:0]         valid_q;
    logic [TAG_W-1:0]         tag_q  [LINES];
    logic [MEM_DATA_BITS-1:0] data_q [LINES*LINE_BEATS];

    logic [WORDS_PER_BEAT-1:0][WORD_BITS-1:0] rd_beat;

    // Valid is the only reset state; a line turns valid only once its tag commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[tag_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we_i) begin
            tag_q[tag_idx_i] <= tag_i;
        end
        if (beat_we_i) begin
            data_q[{beat_idx_i, beat_sel_i}] <= beat_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_beat    = data_q[{rd_idx_i, rd_wsel_i[WSEL_W-1:WPB_W]}];
    assign rd_word_o  = rd_beat[rd_wsel_i[WPB_W-1:0]];

endmodule

// File: rtl/icache_ro.sv
// Read-only direct-mapped instruction cache: 1-cycle hit lookup, stall and
// single-line refill over a valid/ready request and beat-wise response channel.
module icache_ro
    import icache_ro_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              icache_addr,
    input  logic                     icache_re,
    output logic [WORD_BITS-1:0]     icache_dout,
    output logic                     stall,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [MEM_ADDR_W-1:0]    mem_req_addr,
    input  logic                     mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_resp_data
);

    icache_state_e           state_q, state_d;
    logic                    req_pend_q, req_pend_d;
    logic [WADDR_W-1:0]      req_addr_q, req_addr_d;
    logic [WORD_BITS-1:0]    dout_q, dout_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                    mem_req_valid_q, mem_req_valid_d;
    logic [MEM_ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;

    logic                    stall_c;
    logic [WORD_BITS-1:0]    dout_c;
    logic                    beat_we;
    logic                    tag_we;
    logic                    rd_valid;
    logic [TAG_W-1:0]        rd_tag;
    logic [WORD_BITS-1:0]    rd_word;
    logic                    hit;
    logic                    unused_addr_lsb;

    logic [IDX_W-1:0]        req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [WSEL_W-1:0]       req_wsel;

    assign unused_addr_lsb = ^icache_addr[1:0];

    assign req_wsel = req_addr_q[WSEL_W-1:0];
    assign req_idx  = req_addr_q[OFF_W-2 +: IDX_W];
    assign req_tag  = req_addr_q[WADDR_W-1 -: TAG_W];
    assign hit      = rd_valid && (rd_tag == req_tag);

    icache_array u_array (
        .clk         (clk),
        .reset       (reset),
        .beat_we_i   (beat_we),
        .beat_idx_i  (req_idx),
        .beat_sel_i  (beat_cnt_q),
        .beat_data_i (mem_resp_data),
        .tag_we_i    (tag_we),
        .tag_idx_i   (req_idx),
        .tag_i       (req_tag),
        .rd_idx_i    (req_idx),
        .rd_wsel_i   (req_wsel),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_word_o   (rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ICACHE_READY;
            req_pend_q      <= 1'b0;
            req_addr_q      <= '0;
            dout_q          <= '0;
            beat_cnt_q      <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            state_q         <= state_d;
            req_pend_q      <= req_pend_d;
            req_addr_q      <= req_addr_d;
            dout_q          <= dout_d;
            beat_cnt_q      <= beat_cnt_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
        end
    end

    // Lookup/accept in READY; refill sequencing in the miss states.
    always_comb begin
        state_d         = state_q;
        req_pend_d      = req_pend_q;
        req_addr_d      = req_addr_q;
        dout_d          = dout_q;
        beat_cnt_d      = beat_cnt_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        stall_c         = 1'b0;
        dout_c          = dout_q;
        beat_we         = 1'b0;
        tag_we          = 1'b0;

        case (state_q)
            ICACHE_READY: begin
                if (req_pend_q && !hit) begin
                    stall_c         = 1'b1;
                    state_d         = ICACHE_MISS_REQ;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = {req_tag, req_idx, BEAT_W'(0)};
                end else begin
                    if (req_pend_q) begin
                        dout_c = rd_word;
                        dout_d = rd_word;
                    end
                    req_pend_d = icache_re;
                    if (icache_re) begin
                        req_addr_d = icache_addr[31:2];
                    end
                end
            end
            ICACHE_MISS_REQ: begin
                stall_c = 1'b1;
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    beat_cnt_d      = '0;
                    state_d         = ICACHE_MISS_RESP;
                end
            end
            ICACHE_MISS_RESP: begin
                stall_c = 1'b1;
                if (mem_resp_valid) begin
                    beat_we    = 1'b1;
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (beat_cnt_q == BEAT_W'(LINE_BEATS - 1)) begin
                        state_d = ICACHE_FILL_DONE;
                    end
                end
            end
            ICACHE_FILL_DONE: begin
                stall_c = 1'b1;
                tag_we  = 1'b1;
                state_d = ICACHE_READY;
            end
            default: begin
                state_d = ICACHE_READY;
            end
        endcase
    end

    assign stall         = stall_c;
    assign icache_dout   = dout_c;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;

endmodule

// File: tb/tb_icache_ro.sv
// Directed bench for icache_ro: fills, hits, conflicts, stalled handshakes,
// reset abort mid-refill and stray response beats.
module tb_icache_ro;

    logic         clk;
    logic         reset;
    logic [31:0]  icache_addr;
    logic         icache_re;
    logic [31:0]  icache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [27:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    int n_vec;
    int n_err;

    icache_ro dut (
        .clk            (clk),
        .reset          (reset),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .icache_dout    (icache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory image: word at byte address a is {a[23:0]^24'h001000, 8'h13}.
    function automatic logic [127:0] mk_beat(input logic [27:0] ba);
        logic [127:0] d;
        logic [31:0]  a;
        d = '0;
        for (int j = 0; j < 4; j++) begin
            a = 32'({ba, 4'h0}) + 32'(4 * j);
            d[32*j +: 32] = {a[23:0] ^ 24'h001000, 8'h13};
        end
        return d;
    endfunction

    // Entered at the negedge of the miss lookup cycle; returns at the negedge of the hit cycle.
    task automatic serve_fill(input logic [27:0] line_a, input int rdy_wait, input int gap);
        chk("lookup_stall", 32'(stall), 32'd1);
        @(negedge clk);
        for (int i = 0; i < rdy_wait; i++) begin
            chk("req_valid_wait", 32'(mem_req_valid), 32'd1);
            chk("req_addr_wait", 32'(mem_req_addr), 32'(line_a));
            chk("stall_req_wait", 32'(stall), 32'd1);
            @(negedge clk);
        end
        chk("req_valid", 32'(mem_req_valid), 32'd1);
        chk("req_addr", 32'(mem_req_addr), 32'(line_a));
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("req_drop", 32'(mem_req_valid), 32'd0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                chk("stall_gap", 32'(stall), 32'd1);
                @(negedge clk);
            end
            chk("stall_beat", 32'(stall), 32'd1);
            mem_resp_valid = 1'b1;
            mem_resp_data  = mk_beat(line_a + 28'(b));
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        chk("fill_done_stall", 32'(stall), 32'd1);
        @(negedge clk);
    endtask

    // Present a request at this negedge, move to the next negedge, drop re.
    task automatic issue(input logic [31:0] a);
        icache_re   = 1'b1;
        icache_addr = a;
        @(negedge clk);
        icache_re   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset          = 1'b1;
        icache_addr    = '0;
        icache_re      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dout", icache_dout, 32'h0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_req_addr", 32'(mem_req_addr), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss on 0x1000
        issue(32'h0000_1000);
        serve_fill(28'h0000100, 0, 0);
        chk("fill_stall_drop", 32'(stall), 32'd0);
        chk("fill_word0", icache_dout, 32'h0000_0013);

        // Back-to-back hits in the same line
        issue(32'h0000_1004);
        chk("hit1_stall", 32'(stall), 32'd0);
        chk("hit1_dout", icache_dout, 32'h0000_0413);
        issue(32'h0000_1008);
        chk("hit2_stall", 32'(stall), 32'd0);
        chk("hit2_dout", icache_dout, 32'h0000_0813);
        issue(32'h0000_103C);
        chk("hit15_stall", 32'(stall), 32'd0);
        chk("hit15_dout", icache_dout, 32'h0000_3C13);
        @(negedge clk);
        chk("idle_hold_dout", icache_dout, 32'h0000_3C13);
        chk("idle_stall", 32'(stall), 32'd0);

        // Conflict: same index, different tag
        issue(32'h0000_1400);
        serve_fill(28'h0000140, 0, 0);
        chk("conf_stall", 32'(stall), 32'd0);
        chk("conf_dout", icache_dout, 32'h0004_0013);

        // Original line was evicted; refill with slow ready and beat gaps
        issue(32'h0000_1000);
        serve_fill(28'h0000100, 5, 2);
        chk("slow_stall", 32'(stall), 32'd0);
        chk("slow_dout", icache_dout, 32'h0000_0013);
        issue(32'h0000_1008);
        chk("slow_hit_dout", icache_dout, 32'h0000_0813);

        // Reset in the middle of a refill after two beats
        issue(32'h0000_2000);
        chk("abort_lookup_stall", 32'(stall), 32'd1);
        @(negedge clk);
        chk("abort_req_valid", 32'(mem_req_valid), 32'd1);
        chk("abort_req_addr", 32'(mem_req_addr), 32'h0000200);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mk_beat(28'h0000200 + 28'(b));
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        chk("abort_pre_stall", 32'(stall), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_async_stall", 32'(stall), 32'd0);
        chk("abort_async_req_valid", 32'(mem_req_valid), 32'd0);
        chk("abort_async_dout", icache_dout, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = mk_beat(28'h0000202);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("stray_stall", 32'(stall), 32'd0);
        chk("stray_req_valid", 32'(mem_req_valid), 32'd0);
        issue(32'h0000_1000);
        serve_fill(28'h0000100, 0, 0);
        chk("post_rst_dout", icache_dout, 32'h0000_0013);

        // Stray response beats while hits are in flight
        icache_re      = 1'b1;
        icache_addr    = 32'h0000_1004;
        mem_resp_valid = 1'b1;
        mem_resp_data  = {4{32'hFFFF_FFFF}};
        @(negedge clk);
        chk("stray_hit1", icache_dout, 32'h0000_0413);
        chk("stray_hit1_stall", 32'(stall), 32'd0);
        icache_addr = 32'h0000_103C;
        @(negedge clk);
        chk("stray_hit2", icache_dout, 32'h0000_3C13);
        mem_resp_valid = 1'b0;
        icache_addr    = 32'h0000_1000;
        @(negedge clk);
        chk("stray_hit3", icache_dout, 32'h0000_0013);
        icache_addr = 32'h0000_1008;
        @(negedge clk);
        icache_re = 1'b0;
        chk("stray_hit4", icache_dout, 32'h0000_0813);
        chk("stray_hit4_stall", 32'(stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
